// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full-adder slice assembled from two sum/carry cells and an OR.

// Sum/carry cell: s = a ^ b, c = a & b.
module serial_sc_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Combinational half-add of the two inputs.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// Full adder: first cell adds the operand bits, second adds the carry-in.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    serial_sc_cell u_cell_ab (
        .a (a),
        .b (b),
        .s (w_s1),
        .c (w_c1)
    );

    serial_sc_cell u_cell_ci (
        .a (w_s1),
        .b (ci),
        .s (s),
        .c (w_c2)
    );

    // Both carries can never be set together, so OR gives the majority.
    always_comb begin
        co = w_c1 | w_c2;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock, LSB first, under start/done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s;
    logic               w_co;

    serial_fa_bit u_fa_bit (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and operand-load decision; start only matters in IDLE/DONE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shift registers, carry flop and bit counter; sum_sr untouched on load
    // so the previous result stays visible until shifting begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_carry  <= w_co;
            r_cnt    <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Outputs come straight from state and registers.
    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
        sum  = r_sum_sr;
        cout = r_carry;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=13.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    logic        start13;
    logic [12:0] a13;
    logic [12:0] b13;
    logic        cin13;
    logic        busy13;
    logic        done13;
    logic [12:0] sum13;
    logic        cout13;

    int passed = 0;
    int total  = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start13),
        .a     (a13),
        .b     (b13),
        .cin   (cin13),
        .busy  (busy13),
        .done  (done13),
        .sum   (sum13),
        .cout  (cout13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 add from IDLE/DONE; checks busy span, done timing and result.
    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic ec, input string tag);
        int busy_n;
        int done_n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        busy_n = 0;
        done_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) done_n++;
        end
        chk({tag, " busy cycles"}, 64'(busy_n), 64'd8);
        chk({tag, " early done"}, 64'(done_n), 64'd0);
        @(negedge clk);
        chk({tag, " done/busy"}, {62'd0, done, busy}, 64'b10);
        chk({tag, " sum"}, 64'(sum), 64'(es));
        chk({tag, " cout"}, 64'(cout), 64'(ec));
    endtask

    // One WIDTH=13 add with a bounded wait for done.
    task automatic add13(input logic [12:0] ia, input logic [12:0] ib, input logic ic);
        logic [13:0] exp;
        logic        seen;
        exp = {1'b0, ia} + {1'b0, ib} + 14'(ic);
        @(negedge clk);
        a13 = ia; b13 = ib; cin13 = ic; start13 = 1'b1;
        @(negedge clk);
        start13 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done13) seen = 1'b1;
        end
        chk("rnd13 done seen", 64'(seen), 64'd1);
        chk("rnd13 result", 64'({cout13, sum13}), 64'(exp));
    endtask

    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic       bb_c [3];
    logic [7:0] bb_s [3];
    logic       bb_o [3];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] re;
        int         cnt_b;
        int         cnt_d;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
        bb_a = '{8'h12, 8'hFF, 8'h80};
        bb_b = '{8'h34, 8'hFF, 8'h7F};
        bb_c = '{1'b0, 1'b1, 1'b1};
        bb_s = '{8'h46, 8'hFF, 8'h00};
        bb_o = '{1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset outputs w8", {53'd0, busy, done, cout, sum}, 64'd0);
        chk("reset outputs w13", {48'd0, busy13, done13, cout13, sum13}, 64'd0);
        rst_n = 1'b1;

        add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        @(negedge clk);
        chk("zero done single pulse", {62'd0, done, busy}, 64'd0);

        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1");
        add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c+0f");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold idle", {53'd0, busy, done, cout, sum}, {53'd0, 3'b000, 8'h4B});
        end

        // start re-asserted mid-add must be ignored
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 4) begin a = 8'h11; start = 1'b1; end
            if (k == 5) start = 1'b0;
        end
        chk("ignore start done", 64'(done), 64'd1);
        chk("ignore start sum", {55'd0, cout, sum}, {55'd0, 1'b0, 8'h03});

        // asynchronous reset during the fifth shift cycle
        @(negedge clk);
        a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid-op busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-op reset outputs", {53'd0, busy, done, cout, sum}, 64'd0);
        #3;
        rst_n = 1'b1;
        cnt_b = 0;
        cnt_d = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) cnt_b++;
            if (done) cnt_d++;
        end
        chk("no done after reset", 64'(cnt_d), 64'd0);
        chk("no busy after reset", 64'(cnt_b), 64'd0);
        add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80+80");

        // back-to-back with start held high
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            cnt_d = 0;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (k < 9 && done) cnt_d++;
            end
            chk("b2b done", 64'(done), 64'd1);
            chk("b2b no early done", 64'(cnt_d), 64'd0);
            chk("b2b result", {55'd0, cout, sum}, {55'd0, bb_o[op], bb_s[op]});
            if (op < 2) begin
                a = bb_a[op+1]; b = bb_b[op+1]; cin = bb_c[op+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b back to idle", {62'd0, busy, done}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            re = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            add8(ra, rb, rc, re[7:0], re[8], "rnd8");
        end

        for (int i = 0; i < 1000; i++) begin
            add13(13'($urandom), 13'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
